// File: rtl/fll_emul_clk_gen.sv
// fll_emul_clk_gen: FPGA stand-in for the silicon FLL.
// Derives SoC, peripheral and cluster clocks from ref_clk_i with 50% duty
// integer dividers, programmed over the FLL request/ack config bus.
// Optional feature: define CLK_GATE_EN to make CTRL[2:0] writable
// per-channel clock enables (otherwise they are fixed at 3'b111).

// One divider channel: counter, active divider, output flop and enable gate.
module fll_emul_clk_chan #(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test_mode,
  input  logic [DIV_W-1:0] div,
  input  logic             en,
  output logic             clk_o
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic             clk_q;
  logic             en_q;

  // Toggle on terminal count; a new divider is adopted only on the falling
  // toggle so an in-flight phase is never shortened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_q   <= 1'b0;
      div_act <= DIV_W'(DIV_RST);
    end else if (cnt == div_act) begin
      cnt   <= '0;
      clk_q <= ~clk_q;
      if (clk_q) div_act <= div;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Enable is sampled only while clk_q is low, so gating never chops a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         en_q <= 1'b1;
    else if (!clk_q) en_q <= en;
  end

  assign clk_o = test_mode ? clk : (clk_q & en_q);
endmodule

module fll_emul_clk_gen #(
  parameter int DIV_W       = 8,
  parameter int SOC_DIV_RST = 0,
  parameter int PER_DIV_RST = 1,
  parameter int CLU_DIV_RST = 0
) (
  input  logic        ref_clk_i,
  input  logic        rst_glob_i,
  input  logic        test_mode_i,
  input  logic        shift_enable_i,
  input  logic        cfg_req_i,
  output logic        cfg_ack_o,
  input  logic [1:0]  cfg_add_i,
  input  logic [31:0] cfg_data_i,
  input  logic        cfg_wrn_i,
  output logic [31:0] cfg_r_data_o,
  output logic        soc_clk_o,
  output logic        per_clk_o,
  output logic        cluster_clk_o
);
  localparam int         NUM_CH = 3;
  localparam logic [7:0] ID     = 8'hA5;
  localparam int         CH_RST [NUM_CH] = '{SOC_DIV_RST, PER_DIV_RST, CLU_DIV_RST};

  typedef struct packed {
    logic        wrn;
    logic [1:0]  add;
    logic [31:0] data;
  } cfg_req_t;

  cfg_req_t                       req;
  logic                           ack_q;
  logic                           wr_en;
  logic [NUM_CH-1:0][DIV_W-1:0]   div_q;
  logic [NUM_CH-1:0]              ctrl_en;
  logic [NUM_CH-1:0]              gen_clk;
  logic [31:0]                    rdata;
  logic                           unused_data;

  assign req         = '{wrn: cfg_wrn_i, add: cfg_add_i, data: cfg_data_i};
  assign unused_data = ^req.data;

  // Ack one cycle after a sampled request; a held request re-arms every other cycle.
  always_ff @(posedge ref_clk_i or posedge rst_glob_i) begin
    if (rst_glob_i) ack_q <= 1'b0;
    else            ack_q <= cfg_req_i & ~ack_q;
  end

  // Writes commit at the end of the ack cycle unless scan shifting is active.
  assign wr_en = ack_q & ~req.wrn & ~shift_enable_i;

  // Pending divider registers.
  always_ff @(posedge ref_clk_i or posedge rst_glob_i) begin
    if (rst_glob_i) begin
      for (int i = 0; i < NUM_CH; i++) div_q[i] <= DIV_W'(CH_RST[i]);
    end else if (wr_en) begin
      case (req.add)
        2'd0:    div_q[0] <= req.data[DIV_W-1:0];
        2'd1:    div_q[1] <= req.data[DIV_W-1:0];
        2'd2:    div_q[2] <= req.data[DIV_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef CLK_GATE_EN
  // Writable channel enables in CTRL[2:0].
  always_ff @(posedge ref_clk_i or posedge rst_glob_i) begin
    if (rst_glob_i)                   ctrl_en <= '1;
    else if (wr_en && req.add == 2'd3) ctrl_en <= req.data[NUM_CH-1:0];
  end
`else
  assign ctrl_en = '1;
`endif

  // Read mux; unused bits read as zero.
  always_comb begin
    rdata = '0;
    case (req.add)
      2'd0:    rdata[DIV_W-1:0] = div_q[0];
      2'd1:    rdata[DIV_W-1:0] = div_q[1];
      2'd2:    rdata[DIV_W-1:0] = div_q[2];
      default: rdata = {ID, {(24-NUM_CH){1'b0}}, ctrl_en};
    endcase
  end

  assign cfg_ack_o    = ack_q;
  assign cfg_r_data_o = ack_q ? rdata : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fll_emul_clk_chan #(.DIV_W(DIV_W), .DIV_RST(CH_RST[g])) u_chan (
      .clk       (ref_clk_i),
      .rst       (rst_glob_i),
      .test_mode (test_mode_i),
      .div       (div_q[g]),
      .en        (ctrl_en[g]),
      .clk_o     (gen_clk[g])
    );
  end

  assign soc_clk_o     = gen_clk[0];
  assign per_clk_o     = gen_clk[1];
  assign cluster_clk_o = gen_clk[2];
endmodule

// File: tb/tb_fll_emul_clk_gen.sv
// Scoreboard bench for fll_emul_clk_gen. Clock outputs are predicted by a
// phase-length model (each high/low phase lasts div+1 cycles, divider picked
// up at the start of a low phase); config reads are queued at issue and
// checked by a monitor whenever the DUT acks.
module tb_fll_emul_clk_gen;
  logic        ref_clk = 1'b0;
  logic        rst = 1'b1;
  logic        test_mode = 1'b0;
  logic        shift_en = 1'b0;
  logic        req = 1'b0;
  logic        wrn = 1'b1;
  logic [1:0]  add = '0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic [31:0] rdata;
  logic        soc, per, clu;
  logic [2:0]  clks;

  int vectors = 0;
  int errors  = 0;

  fll_emul_clk_gen dut (
    .ref_clk_i      (ref_clk),
    .rst_glob_i     (rst),
    .test_mode_i    (test_mode),
    .shift_enable_i (shift_en),
    .cfg_req_i      (req),
    .cfg_ack_o      (ack),
    .cfg_add_i      (add),
    .cfg_data_i     (wdata),
    .cfg_wrn_i      (wrn),
    .cfg_r_data_o   (rdata),
    .soc_clk_o      (soc),
    .per_clk_o      (per),
    .cluster_clk_o  (clu)
  );

  assign clks = {clu, per, soc};

  always #5 ref_clk = ~ref_clk;

  // Reference model state
  localparam int RSTV [3] = '{0, 1, 0};
  int          mdiv [3];
  int          mdcur [3];
  int          mleft [3];
  bit          mlvl [3];
  bit          men [3];
  bit [2:0]    mctrl;
  bit          pend_wr = 1'b0;
  bit [1:0]    pend_add;
  bit [31:0]   pend_data;
  logic [32:0] exp_q [$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_exp(input bit [1:0] a);
    if (a < 2'd3) return 32'(mdiv[a]);
    return {8'hA5, 21'd0, mctrl};
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        mdiv[c]  = RSTV[c];
        mdcur[c] = RSTV[c];
        mleft[c] = RSTV[c] + 1;
        mlvl[c]  = 1'b0;
        men[c]   = 1'b1;
      end
      mctrl = 3'b111;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (!mlvl[c]) men[c] = mctrl[c];
        mleft[c]--;
        if (mleft[c] == 0) begin
          mlvl[c] = !mlvl[c];
          if (!mlvl[c]) mdcur[c] = mdiv[c];
          mleft[c] = mdcur[c] + 1;
        end
      end
      if (pend_wr) begin
        if (pend_add < 2'd3) mdiv[pend_add] = int'(pend_data[7:0]);
`ifdef CLK_GATE_EN
        else mctrl = pend_data[2:0];
`endif
        pend_wr = 1'b0;
      end
    end
  endtask

  initial begin
    model_step();
    forever begin
      @(posedge ref_clk or posedge rst);
      model_step();
    end
  end

  task automatic check_clocks(input bit hi);
    for (int c = 0; c < 3; c++)
      cmp($sformatf("clk%0d_%s", c, hi ? "hi" : "lo"), 32'(clks[c]),
          test_mode ? 32'(hi) : 32'(mlvl[c] & men[c]));
  endtask

  // Monitor: clocks sampled in both ref phases, bus checked on every cycle.
  initial begin
    logic [32:0] e;
    forever begin
      @(posedge ref_clk);
      #3;
      check_clocks(1'b1);
      if (ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          cmp("ack_unexpected", 32'(ack), 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e[32]) cmp("rdata", rdata, e[31:0]);
        end
      end else begin
        cmp("rdata_idle", rdata, 32'd0);
      end
      #4;
      check_clocks(1'b0);
    end
  end

  task automatic access(input bit w, input bit [1:0] a, input bit [31:0] d, input bit se);
    int n;
    @(negedge ref_clk);
    wrn = w; add = a; wdata = d; shift_en = se; req = 1'b1;
    exp_q.push_back({w, w ? rd_exp(a) : 32'd0});
    n = 0;
    do begin
      @(posedge ref_clk);
      #3;
      n++;
    end while (ack !== 1'b1 && n < 4);
    cmp("ack_latency", 32'(n), 32'd1);
    if (ack === 1'b1 && !w && !se) begin
      pend_add = a; pend_data = d; pend_wr = 1'b1;
    end
    @(posedge ref_clk);
    @(negedge ref_clk);
    req = 1'b0; shift_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ref_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] d;
    // reset held: outputs and bus quiet
    idle(4);
    rst = 1'b0;
    idle(20);
    // reset values readback
    access(1'b1, 2'd1, 32'd0, 1'b0);
    access(1'b1, 2'd3, 32'd0, 1'b0);
    access(1'b1, 2'd0, 32'd0, 1'b0);
    // soc divider 3 mid-period
    idle(1);
    access(1'b0, 2'd0, 32'd3, 1'b0);
    idle(30);
    access(1'b1, 2'd0, 32'd0, 1'b0);
    // write blocked by shift enable
    access(1'b0, 2'd2, 32'd5, 1'b1);
    access(1'b1, 2'd2, 32'd0, 1'b0);
    idle(12);
    // test mode bypass
    test_mode = 1'b1;
    idle(7);
    test_mode = 1'b0;
    idle(20);
    // maximum divider, upper data bits ignored
    access(1'b0, 2'd1, 32'hDEAD_BEFF, 1'b0);
    access(1'b1, 2'd1, 32'd0, 1'b0);
    idle(1100);
    access(1'b0, 2'd1, 32'd0, 1'b0);
    idle(10);
    // clock gating (no effect unless the feature is built in)
    access(1'b0, 2'd3, 32'h0000_0006, 1'b0);
    idle(30);
    access(1'b1, 2'd3, 32'd0, 1'b0);
    access(1'b0, 2'd3, 32'h0000_0007, 1'b0);
    idle(30);
    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      d = ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 9);
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d,
             ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) begin
        test_mode = 1'b1;
        idle($urandom_range(1, 4));
        test_mode = 1'b0;
      end
      idle($urandom_range(0, 15));
    end
    // reset during an access aborts it
    @(negedge ref_clk);
    wrn = 1'b1; add = 2'd0; req = 1'b1; rst = 1'b1;
    repeat (2) begin
      @(posedge ref_clk);
      #3;
      cmp("abort_ack", 32'(ack), 32'd0);
    end
    @(negedge ref_clk);
    req = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(20);
    access(1'b1, 2'd0, 32'd0, 1'b0);
    idle(5);
    cmp("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
